vga_capture_rx: RTL and testbench
=================================

VGA_CAPTURE_RX -- requirements
Module: vga_capture_rx

Interface
REQ-001 The block SHALL have parameters ACTIVE_HORI 640, FRONT_PORCH_HORI 16, SYNC_PULSE_HORI 96, BACK_PORCH_HORI 48, ACTIVE_VERT 480, FRONT_PORCH_VERT 10, SYNC_PULSE_VERT 2, BACK_PORCH_VERT 33 and FIFO_DEPTH 4 (entries, power of two).
REQ-002 The block SHALL have ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  pixel strobe, one clk cycle per pixel period.
- HSYNC  in  1  horizontal sync, active-low.
- VSYNC  in  1  vertical sync, active-low.
- RED, GREEN, BLUE  in  4 each  incoming colour.
- pix_data  out  12  {RED,GREEN,BLUE}.
- pix_x, pix_y  out  10 each  pixel coordinates.
- pix_sof  out  1  marks pixel (0,0).
- pix_valid  out  1  output entry available.
- pix_ready  in  1  consumer accepts entry.
- locked  out  1  counters aligned to the incoming frame.
- overflow  out  1  sticky flag: pixel dropped.
- timing_err  out  1  sticky flag: sync position mismatch.

Function
REQ-003 HSYNC, VSYNC and colour SHALL be sampled only on clk edges where enable=1; all other cycles SHALL leave the counters and edge detectors unchanged.
REQ-004 Internal h_cnt SHALL increment per strobe, wrapping from HTOT-1 to 0, where HTOT = sum of the horizontal parameters (800); each wrap SHALL increment v_cnt, which wraps from VTOT-1 to 0 (VTOT = 525).
REQ-005 A strobe sampling HSYNC=0 after a previous strobe sampled 1 (HSYNC fall) SHALL load h_cnt with ACTIVE_HORI+FRONT_PORCH_HORI (656).
REQ-006 A VSYNC fall SHALL load v_cnt with ACTIVE_VERT+FRONT_PORCH_VERT (490).
REQ-007 The FSM SHALL have states UNLOCKED, SYNCING and LOCKED, with these transitions:
- UNLOCKED -> SYNCING on VSYNC fall.
- SYNCING -> LOCKED on the strobe where h_cnt and v_cnt both wrap to 0.
- LOCKED -> UNLOCKED only per REQ-013.
REQ-008 locked SHALL be 1 exactly in LOCKED.
REQ-009 In LOCKED, each strobe with h_cnt<640 and v_cnt<480 SHALL write one FIFO entry {colour, h_cnt, v_cnt, sof=(h_cnt==0 && v_cnt==0)}; no entries SHALL be written in other states or in blanking.
REQ-010 Latency: the strobe edge SHALL register the pixel, and the following clk SHALL write it to the FIFO; with the FIFO empty, pix_valid SHALL rise 2 clk after the strobe edge.
REQ-011 The output handshake SHALL follow these rules:
- An entry transfers when pix_valid && pix_ready.
- pix_data, pix_x, pix_y and pix_sof SHALL hold stable while pix_valid && !pix_ready.
- Simultaneous read and write on a full FIFO SHALL succeed with no drop.
REQ-012 A write to a full FIFO (without a simultaneous read) SHALL drop the pixel and set overflow, which stays 1 until reset.
REQ-013 (Only with the macro) In LOCKED, an HSYNC fall arriving when the predicted h_cnt is not 655 SHALL set timing_err (sticky) and force UNLOCKED. The FIFO contents SHALL be kept.

Reset
REQ-014 While rst_n=0, the block SHALL force: state UNLOCKED, h_cnt=v_cnt=0, edge-detector history=1 (sync idle), FIFO empty, and pix_valid, locked, overflow, timing_err, pix_sof=0, with pix_data, pix_x, pix_y=0.
REQ-015 Reset mid-frame SHALL discard all buffered pixels, and capture SHALL resume only after a new VSYNC fall followed by the frame wrap.

Configuration
REQ-016 With VGA_RX_TIMING_CHECK_EN defined, REQ-013 SHALL be compiled in. Without it, HSYNC falls SHALL only realign h_cnt per REQ-005, timing_err SHALL be tied to 0, and LOCKED SHALL be exited only by reset.

Structure
REQ-017 Package vga_rx_pkg SHALL hold the default timing constants, the HTOT/VTOT derivations, the FSM state enum and the packed FIFO entry struct (33 bits).
REQ-018 The FIFO SHALL be a single sub-module, vga_rx_fifo (synchronous, parameterised width/depth, full/empty flags); the top SHALL contain the counters, the FSM and the input register.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Lock: enable every 4th clk, standard 640x480 frames, pix_ready=1 -> locked=1 at start of frame 2; exactly 307200 entries per frame after lock; first entry pix_sof=1 at (0,0), last at (639,479).
- Latency: pixel strobe with colour 12'hA5C at (0,0), FIFO empty -> pix_valid=1 and pix_data=12'hA5C exactly 2 clk later.
- Backpressure: pix_ready=0 for 5 strobes inside the active area -> 4 entries held unchanged and the 5th dropped; overflow=1 and stays 1 after pix_ready returns.
- Full plus simultaneous read/write: FIFO full, pix_ready=1 on a write cycle -> no drop, overflow stays 0.
- Timing fault (macro on): HSYNC fall shifted 3 strobes early in line 100 -> timing_err=1, locked=0, relock after the next VSYNC fall plus frame wrap; macro off -> timing_err=0, locked stays 1.
- Reset mid-line at (320,200) with 3 entries buffered -> pix_valid=0 next clk, locked=0, and no entries until relock.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: default 640x480 timing, frame totals, FSM states and the FIFO entry layout.
package vga_rx_pkg;
  localparam int DEF_ACTIVE_HORI = 640;
  localparam int DEF_FRONT_PORCH_HORI = 16;
  localparam int DEF_SYNC_PULSE_HORI = 96;
  localparam int DEF_BACK_PORCH_HORI = 48;
  localparam int DEF_ACTIVE_VERT = 480;
  localparam int DEF_FRONT_PORCH_VERT = 10;
  localparam int DEF_SYNC_PULSE_VERT = 2;
  localparam int DEF_BACK_PORCH_VERT = 33;
  localparam int DEF_FIFO_DEPTH = 4;
  function automatic int tot(int active, int front, int sync, int back);
    return active + front + sync + back;
  endfunction
  localparam int DEF_HTOT = tot(DEF_ACTIVE_HORI, DEF_FRONT_PORCH_HORI, DEF_SYNC_PULSE_HORI, DEF_BACK_PORCH_HORI);
  localparam int DEF_VTOT = tot(DEF_ACTIVE_VERT, DEF_FRONT_PORCH_VERT, DEF_SYNC_PULSE_VERT, DEF_BACK_PORCH_VERT);
  typedef enum logic [1:0] {UNLOCKED, SYNCING, LOCKED} state_t;
  typedef struct packed {
    logic [11:0] data;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        sof;
  } entry_t;
endpackage

// File: rtl/vga_capture_rx_if.sv
// vga_capture_rx_if: valid/ready pixel stream leaving the capture block.
interface vga_capture_rx_if;
  logic [11:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_sof;
  logic        pix_valid;
  logic        pix_ready;
  modport master(output pix_data, pix_x, pix_y, pix_sof, pix_valid, input pix_ready);
  modport slave(input pix_data, pix_x, pix_y, pix_sof, pix_valid, output pix_ready);
endinterface

// File: rtl/vga_capture_rx_fifo.sv
// vga_rx_fifo: synchronous show-ahead FIFO; a read frees a slot for a same-cycle write when full.
module vga_rx_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic wr, rd;
  assign rd = rd_en && !empty;
  assign wr = wr_en && (!full || rd);
  assign empty = wptr == rptr;
  assign full = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
  assign dout = empty ? '0 : mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + (AW+1)'(1);
      if (rd) rptr <= rptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/vga_capture_rx.sv
// vga_capture_rx: locks h/v counters to incoming VGA syncs and streams active pixels through a FIFO.
// Define VGA_RX_TIMING_CHECK_EN to drop lock (and flag timing_err) on a misplaced HSYNC fall.
module vga_capture_rx
  import vga_rx_pkg::*;
#(
  parameter int ACTIVE_HORI      = DEF_ACTIVE_HORI,
  parameter int FRONT_PORCH_HORI = DEF_FRONT_PORCH_HORI,
  parameter int SYNC_PULSE_HORI  = DEF_SYNC_PULSE_HORI,
  parameter int BACK_PORCH_HORI  = DEF_BACK_PORCH_HORI,
  parameter int ACTIVE_VERT      = DEF_ACTIVE_VERT,
  parameter int FRONT_PORCH_VERT = DEF_FRONT_PORCH_VERT,
  parameter int SYNC_PULSE_VERT  = DEF_SYNC_PULSE_VERT,
  parameter int BACK_PORCH_VERT  = DEF_BACK_PORCH_VERT,
  parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       HSYNC,
  input  logic       VSYNC,
  input  logic [3:0] RED,
  input  logic [3:0] GREEN,
  input  logic [3:0] BLUE,
  vga_capture_rx_if.master pix,
  output logic       locked,
  output logic       overflow,
  output logic       timing_err
);
  localparam int HTOT = tot(ACTIVE_HORI, FRONT_PORCH_HORI, SYNC_PULSE_HORI, BACK_PORCH_HORI);
  localparam int VTOT = tot(ACTIVE_VERT, FRONT_PORCH_VERT, SYNC_PULSE_VERT, BACK_PORCH_VERT);
  localparam int H_LOAD = ACTIVE_HORI + FRONT_PORCH_HORI;
  localparam int V_LOAD = ACTIVE_VERT + FRONT_PORCH_VERT;
  state_t state, state_nx;
  logic [9:0] h_cnt, v_cnt;
  logic hs_d, vs_d, h_fall, v_fall, h_wrap, v_wrap, fault, capture, wr_pend, rd, full, empty;
  entry_t ent, q;
  assign h_fall = enable && hs_d && !HSYNC;
  assign v_fall = enable && vs_d && !VSYNC;
  assign h_wrap = h_cnt == 10'(HTOT - 1);
  assign v_wrap = v_cnt == 10'(VTOT - 1);
  assign capture = enable && state == LOCKED && !fault && h_cnt < 10'(ACTIVE_HORI) && v_cnt < 10'(ACTIVE_VERT);
  assign locked = state == LOCKED;
  assign rd = pix.pix_valid && pix.pix_ready;
`ifdef VGA_RX_TIMING_CHECK_EN
  assign fault = state == LOCKED && h_fall && h_cnt != 10'(H_LOAD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timing_err <= 1'b0;
    else if (fault) timing_err <= 1'b1;
`else
  assign fault = 1'b0;
  assign timing_err = 1'b0;
`endif
  // lock only on a clean wrap, not when a sync edge reloads either counter
  always_comb begin
    state_nx = state;
    if (state == UNLOCKED && v_fall) state_nx = SYNCING;
    else if (state == SYNCING && enable && h_wrap && v_wrap && !h_fall && !v_fall) state_nx = LOCKED;
    else if (fault) state_nx = UNLOCKED;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= UNLOCKED;
      h_cnt <= '0;
      v_cnt <= '0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      wr_pend <= 1'b0;
      ent <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      wr_pend <= capture;
      if (capture) ent <= {RED, GREEN, BLUE, h_cnt, v_cnt, h_cnt == '0 && v_cnt == '0};
      if (wr_pend && full && !rd) overflow <= 1'b1;
      if (enable) begin
        hs_d <= HSYNC;
        vs_d <= VSYNC;
        h_cnt <= h_fall ? 10'(H_LOAD) : h_wrap ? '0 : h_cnt + 10'd1;
        v_cnt <= v_fall ? 10'(V_LOAD) : !h_wrap || h_fall ? v_cnt : v_wrap ? '0 : v_cnt + 10'd1;
      end
    end
  vga_rx_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_pend), .din(ent), .rd_en(rd),
    .dout(q), .full(full), .empty(empty)
  );
  assign pix.pix_valid = !empty;
  assign pix.pix_data = q.data;
  assign pix.pix_x = q.x;
  assign pix.pix_y = q.y;
  assign pix.pix_sof = q.sof;
endmodule

// File: tb/tb_vga_capture_rx.sv
// tb_vga_capture_rx: directed frames on a shrunken 8x4 raster (14x8 total), one strobe every 4th clk.
module tb_vga_capture_rx;
  import vga_rx_pkg::*;
  localparam int AH = 8, FPH = 2, SPH = 2, BPH = 2;
  localparam int AV = 4, FPV = 1, SPV = 1, BPV = 2;
  localparam int HT = AH + FPH + SPH + BPH;
  localparam int VT = AV + FPV + SPV + BPV;
  localparam int FR = HT * VT;
  localparam int H0 = AH + FPH - 1;
  localparam int V0 = AV + FPV;
  typedef struct {int idx; int x; int y; logic sof; logic [11:0] data;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [3:0] red = '0, green = '0, blue = '0;
  logic locked, overflow, timing_err;
  int checks = 0, errors = 0;
  int early_y = -1;
  entry_t rx_q[$];
  vec_t tab[6];
  vga_capture_rx_if pix();
  vga_capture_rx #(
    .ACTIVE_HORI(AH), .FRONT_PORCH_HORI(FPH), .SYNC_PULSE_HORI(SPH), .BACK_PORCH_HORI(BPH),
    .ACTIVE_VERT(AV), .FRONT_PORCH_VERT(FPV), .SYNC_PULSE_VERT(SPV), .BACK_PORCH_VERT(BPV),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .HSYNC(hsync), .VSYNC(vsync),
    .RED(red), .GREEN(green), .BLUE(blue), .pix(pix),
    .locked(locked), .overflow(overflow), .timing_err(timing_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (pix.pix_valid && pix.pix_ready) rx_q.push_back({pix.pix_data, pix.pix_x, pix.pix_y, pix.pix_sof});
  function automatic logic [11:0] colf(int x, int y);
    return {4'(x), 4'(y), 4'(x + y)};
  endfunction
  function automatic entry_t exp_entry(int x, int y);
    logic o = x == 0 && y == 0;
    return {o ? 12'hA5C : colf(x, y), 10'(x), 10'(y), o};
  endfunction
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_px(int p);
    int x = p % HT, y = p / HT;
    int hs0 = (y == early_y) ? H0 - 3 : H0;
    hsync = !(x >= hs0 && x < hs0 + SPH);
    vsync = !(y >= V0 && y < V0 + SPV);
    {red, green, blue} = (p == 0) ? 12'hA5C : colf(x, y);
    enable = 1'b1;
  endtask
  task automatic send(int p);
    set_px(p);
    tick(1);
    enable = 1'b0;
    tick(3);
  endtask
  task automatic run(int p0, int p1);
    for (int p = p0; p < p1; p++) send(p);
  endtask
  task automatic check_full_frame(string name);
    int bad = 0;
    check({name, "_count"}, rx_q.size(), AH * AV);
    for (int i = 0; i < rx_q.size() && i < AH * AV; i++)
      if (rx_q[i] !== exp_entry(i % AH, i / AH)) bad++;
    check({name, "_order"}, bad, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tab = '{'{0, 0, 0, 1'b1, 12'hA5C}, '{1, 1, 0, 1'b0, 12'h101}, '{7, 7, 0, 1'b0, 12'h707},
            '{8, 0, 1, 1'b0, 12'h011}, '{20, 4, 2, 1'b0, 12'h426}, '{31, 7, 3, 1'b0, 12'h73A}};
    pix.pix_ready = 1'b1;
    tick(2);
    check("rst_valid", pix.pix_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timing_err", timing_err, 0);
    check("rst_out", {pix.pix_data, pix.pix_x, pix.pix_y, pix.pix_sof}, 0);
    rst_n = 1'b1;
    tick(1);
    // partial first frame starting off-origin so both counters must realign
    run(2 * HT + 5, FR - 1);
    check("prelock_locked", locked, 0);
    check("prelock_entries", rx_q.size(), 0);
    send(FR - 1);
    check("lock_at_frame2", locked, 1);
    rx_q.delete();
    set_px(0);
    tick(1);
    check("lat_valid_1clk", pix.pix_valid, 0);
    enable = 1'b0;
    tick(1);
    check("lat_valid_2clk", pix.pix_valid, 1);
    check("lat_data", pix.pix_data, 12'hA5C);
    check("lat_xy_sof", {pix.pix_x, pix.pix_y, pix.pix_sof}, 21'd1);
    tick(2);
    run(1, FR);
    check_full_frame("f2");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("tab%0d_data", i), rx_q[tab[i].idx].data, tab[i].data);
      check($sformatf("tab%0d_xy", i), {rx_q[tab[i].idx].x, rx_q[tab[i].idx].y}, {10'(tab[i].x), 10'(tab[i].y)});
      check($sformatf("tab%0d_sof", i), rx_q[tab[i].idx].sof, tab[i].sof);
    end
    rx_q.delete();
    run(0, HT);
    pix.pix_ready = 1'b0;
    run(HT, HT + 4);
    check("full_hold", {pix.pix_valid, pix.pix_x, pix.pix_y}, {1'b1, 10'd0, 10'd1});
    set_px(HT + 4);
    tick(1);
    enable = 1'b0;
    pix.pix_ready = 1'b1;
    tick(1);
    pix.pix_ready = 1'b0;
    check("rw_full_overflow", overflow, 0);
    check("rw_full_front", pix.pix_x, 1);
    tick(2);
    pix.pix_ready = 1'b1;
    run(HT + 5, FR);
    check_full_frame("f3");
    check("f3_overflow", overflow, 0);
    rx_q.delete();
    run(0, HT);
    pix.pix_ready = 1'b0;
    run(HT, HT + 3);
    check("bp_hold_mid", {pix.pix_data, pix.pix_x, pix.pix_y}, {12'h011, 10'd0, 10'd1});
    run(HT + 3, HT + 5);
    check("bp_hold_end", {pix.pix_data, pix.pix_x, pix.pix_y}, {12'h011, 10'd0, 10'd1});
    check("bp_overflow", overflow, 1);
    pix.pix_ready = 1'b1;
    run(HT + 5, FR);
    check("bp_count", rx_q.size(), AH * AV - 1);
    check("bp_last_kept", rx_q[11], exp_entry(3, 1));
    check("bp_after_drop", rx_q[12], exp_entry(5, 1));
    check("bp_overflow_sticky", overflow, 1);
    rx_q.delete();
    early_y = 2;
    run(0, 2 * HT + H0 - 3);
    check("tf_pre_locked", locked, 1);
    send(2 * HT + H0 - 3);
`ifdef VGA_RX_TIMING_CHECK_EN
    check("tf_timing_err", timing_err, 1);
    check("tf_locked", locked, 0);
`else
    check("tf_timing_err", timing_err, 0);
    check("tf_locked", locked, 1);
`endif
    run(2 * HT + H0 - 2, FR);
    early_y = -1;
`ifdef VGA_RX_TIMING_CHECK_EN
    check("tf_kept_entries", rx_q.size(), 2 * AH + H0 - 3);
`endif
    check("tf_relocked", locked, 1);
    rx_q.delete();
    run(0, FR);
    check_full_frame("f6");
    rx_q.delete();
    run(0, 2 * HT + 1);
    pix.pix_ready = 1'b0;
    run(2 * HT + 1, 2 * HT + 4);
    check("mr_buffered", pix.pix_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mr_async_valid", pix.pix_valid, 0);
    tick(1);
    check("mr_valid_next", pix.pix_valid, 0);
    check("mr_locked", locked, 0);
    check("mr_flags", {overflow, timing_err}, 0);
    rst_n = 1'b1;
    pix.pix_ready = 1'b1;
    rx_q.delete();
    run(2 * HT + 4, FR - 1);
    check("mr_no_entries", rx_q.size(), 0);
    check("mr_prelock", locked, 0);
    send(FR - 1);
    check("mr_relock", locked, 1);
    rx_q.delete();
    run(0, FR);
    check_full_frame("f8");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
